// File: rtl/spi_flash_seq.sv
// spi_flash_seq: expands one flash request into WREN/OP/RDSR
// transactions for the spi_flash_cmd engine.
//
// Params : ADDR_W (24|32), CMD_GAP (1..15), POLL_MAX (0=unlimited)
// Ports  : clk, rst_n
//          i_cmd, i_cmd_valid, i_addr, i_byte_size  request in
//          o_cmd_ack, o_cmd_err, o_busy             request status
//          o_eng_cmd, o_eng_cmd_valid, o_eng_addr,
//          o_eng_byte_size                          engine request
//          i_eng_cmd_ack, i_eng_status              engine response
// Macro  : FLASH_WEL_CHECK_EN adds an RDSR check of WEL after WREN,
//          retrying WREN up to 3 attempts in total.

module spi_flash_seq #(
  parameter int unsigned ADDR_W   = 24,
  parameter int unsigned CMD_GAP  = 4,
  parameter int unsigned POLL_MAX = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        i_cmd,
  input  logic              i_cmd_valid,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [8:0]        i_byte_size,
  output logic              o_cmd_ack,
  output logic              o_cmd_err,
  output logic              o_busy,
  output logic [7:0]        o_eng_cmd,
  output logic              o_eng_cmd_valid,
  output logic [ADDR_W-1:0] o_eng_addr,
  output logic [8:0]        o_eng_byte_size,
  input  logic              i_eng_cmd_ack,
  input  logic [7:0]        i_eng_status
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GAP,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    PH_WREN,
    PH_WELCHK,
    PH_OP,
    PH_POLL
  } phase_t;

  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_FREAD = 8'h0B;
  localparam logic [7:0] OP_PP    = 8'h02;
  localparam logic [7:0] OP_SE64  = 8'hD8;
  localparam logic [7:0] OP_SE4   = 8'h20;
  localparam logic [7:0] OP_BE    = 8'hC7;
  localparam logic [7:0] OP_WREN  = 8'h06;
  localparam logic [7:0] OP_RDSR  = 8'h05;

  localparam logic [3:0]  GAP_LAST = 4'(CMD_GAP - 1);
  localparam logic [15:0] PMAX     = 16'(POLL_MAX);

  function automatic logic is_rd(input logic [7:0] c);
    return (c == OP_READ) || (c == OP_FREAD);
  endfunction

  function automatic logic is_sup(input logic [7:0] c);
    return is_rd(c) || (c == OP_PP) || (c == OP_SE64) ||
           (c == OP_SE4) || (c == OP_BE);
  endfunction

  // 4-byte-address opcode variants; BE has no address
  function automatic logic [7:0] map_op(input logic [7:0] c);
    logic [7:0] m;
    m = c;
    if (ADDR_W == 32) begin
      case (c)
        OP_READ:  m = 8'h13;
        OP_FREAD: m = 8'h0C;
        OP_PP:    m = 8'h12;
        OP_SE64:  m = 8'hDC;
        OP_SE4:   m = 8'h21;
        default:  m = c;
      endcase
    end
    return m;
  endfunction

  state_t            state, state_d;
  phase_t            phase, phase_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [8:0]        size_q, size_d;
  logic [3:0]        gap_cnt, gap_d;
  logic [15:0]       poll_cnt, poll_d;
  logic              err_q, err_d;
`ifdef FLASH_WEL_CHECK_EN
  logic [1:0]        wel_cnt, wel_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      phase    <= PH_WREN;
      cmd_q    <= '0;
      addr_q   <= '0;
      size_q   <= '0;
      gap_cnt  <= '0;
      poll_cnt <= '0;
      err_q    <= 1'b0;
`ifdef FLASH_WEL_CHECK_EN
      wel_cnt  <= '0;
`endif
    end else begin
      state    <= state_d;
      phase    <= phase_d;
      cmd_q    <= cmd_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      gap_cnt  <= gap_d;
      poll_cnt <= poll_d;
      err_q    <= err_d;
`ifdef FLASH_WEL_CHECK_EN
      wel_cnt  <= wel_d;
`endif
    end
  end

  always_comb begin
    state_d = state;
    phase_d = phase;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    size_d  = size_q;
    gap_d   = gap_cnt;
    poll_d  = poll_cnt;
    err_d   = err_q;
`ifdef FLASH_WEL_CHECK_EN
    wel_d   = wel_cnt;
`endif
    unique case (state)
      S_IDLE: begin
        if (i_cmd_valid) begin
          cmd_d  = i_cmd;
          addr_d = i_addr;
          size_d = i_byte_size;
          gap_d  = '0;
          if (is_sup(i_cmd)) begin
            state_d = S_GAP;
            phase_d = is_rd(i_cmd) ? PH_OP : PH_WREN;
          end else begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt == GAP_LAST) state_d = S_ISSUE;
        else gap_d = gap_cnt + 4'd1;
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (i_eng_cmd_ack) begin
          gap_d   = '0;
          state_d = S_GAP;
          unique case (phase)
            PH_WREN: begin
`ifdef FLASH_WEL_CHECK_EN
              phase_d = PH_WELCHK;
`else
              phase_d = PH_OP;
`endif
            end
            PH_WELCHK: begin
`ifdef FLASH_WEL_CHECK_EN
              if (i_eng_status[1]) begin
                phase_d = PH_OP;
              end else if (wel_cnt == 2'd2) begin
                state_d = S_DONE;
                err_d   = 1'b1;
              end else begin
                wel_d   = wel_cnt + 2'd1;
                phase_d = PH_WREN;
              end
`else
              state_d = S_DONE;
              err_d   = 1'b1;
`endif
            end
            PH_OP: begin
              if (is_rd(cmd_q)) state_d = S_DONE;
              else phase_d = PH_POLL;
            end
            PH_POLL: begin
              if (!i_eng_status[0]) begin
                state_d = S_DONE;
              end else begin
                poll_d = poll_cnt + 16'd1;
                if (POLL_MAX != 0 && poll_d == PMAX) begin
                  state_d = S_DONE;
                  err_d   = 1'b1;
                end
              end
            end
            default: begin
              state_d = S_DONE;
              err_d   = 1'b1;
            end
          endcase
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        phase_d = PH_WREN;
        poll_d  = '0;
        err_d   = 1'b0;
        gap_d   = '0;
`ifdef FLASH_WEL_CHECK_EN
        wel_d   = '0;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // opcode is only presented while a transaction is in flight
  always_comb begin
    o_eng_cmd = 8'h00;
    if (state == S_ISSUE || state == S_WAIT) begin
      unique case (phase)
        PH_WREN:   o_eng_cmd = OP_WREN;
        PH_WELCHK: o_eng_cmd = OP_RDSR;
        PH_OP:     o_eng_cmd = map_op(cmd_q);
        PH_POLL:   o_eng_cmd = OP_RDSR;
        default:   o_eng_cmd = 8'h00;
      endcase
    end
  end

  assign o_busy          = (state != S_IDLE);
  assign o_cmd_ack       = (state == S_DONE);
  assign o_cmd_err       = o_cmd_ack & err_q;
  assign o_eng_cmd_valid = (state == S_ISSUE);
  assign o_eng_addr      = addr_q;
  assign o_eng_byte_size = size_q;

  logic unused_st;
`ifdef FLASH_WEL_CHECK_EN
  assign unused_st = ^i_eng_status[7:2];
`else
  assign unused_st = ^i_eng_status[7:1];
`endif

endmodule
